ibex_instr_mem_responder: RTL and testbench
===========================================

// Module: ibex_instr_mem_responder
// PURPOSE
//  Responder end of the core's instruction-fetch bus (req/gnt/rvalid/rdata/err).
//  Serves word reads from an internal RAM with a fixed pipelined response latency.
//  Sits between the fetch port of the core and the testbench/SoC fabric.
//  Also used as the reference instruction memory in core-level benches.
// PARAMETERS
//  MemWords    4096          RAM depth in 32-bit words; power of two, >=16
//  BaseAddr    32'h0000_0000 byte address of word 0; aligned to MemWords*4
//  RspLatency  2             cycles from grant to rvalid; legal range 1..8
// PORTS
//  clk_i           in   1      clock
//  rst_ni          in   1      asynchronous reset, active low
//  instr_req_i     in   1      fetch request; held by initiator until granted
//  instr_addr_i    in   32     fetch byte address; bits [1:0] ignored
//  instr_gnt_o     out  1      request accepted this cycle
//  instr_rvalid_o  out  1      response valid; single-cycle pulse per grant
//  instr_rdata_o   out  32     read data; 0 when instr_err_o=1
//  instr_err_o     out  1      bus error; qualified by instr_rvalid_o
//  mem_we_i        in   1      preload write enable
//  mem_waddr_i     in   AW     preload word index, AW=$clog2(MemWords)
//  mem_wdata_i     in   32     preload write data
//  outstanding_o   out  4      granted requests not yet answered, 0..RspLatency
// BEHAVIOUR
//  - Reset values: instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0,
//    instr_err_o=0, outstanding_o=0. All response pipeline valid bits clear.
//    RAM contents are not reset.
//  - Grant: instr_gnt_o = instr_req_i & ~stall. It is combinational, so it can
//    assert in the same cycle as the request. Without the optional feature,
//    stall=0.
//  - Address decode happens in the grant cycle. idx = (addr - BaseAddr) >> 2.
//    A request is in range when addr >= BaseAddr and idx < MemWords.
//  - In range: rdata = RAM[idx], read in the grant cycle, and err=0.
//    Out of range: rdata=0 and err=1.
//  - Response pipeline: RspLatency stages of {valid, err, rdata}. Stage 0 loads
//    on grant, then the pipeline shifts every cycle.
//  - Latency: a grant in cycle N gives rvalid in cycle N+RspLatency.
//    Responses come back strictly in order. rvalid has no backpressure.
//  - Back-to-back grants are allowed every cycle, giving full throughput.
//    outstanding_o never exceeds RspLatency.
//  - outstanding_o: +1 on gnt, -1 on rvalid, unchanged when both happen in the
//    same cycle.
//  - Preload write: the RAM updates at the clock edge. A same-cycle grant to
//    the same index returns the OLD data (read-before-write). Preload is
//    allowed while fetches are in flight.
//  - When rvalid=0, rdata and err hold 0 (not stale data).
//  - Reset mid-operation drops all in-flight responses; no rvalid follows
//    after reset is released.
//  - Assertions: instr_addr_i stable while req&~gnt (warning only);
//    RspLatency in 1..8.
// CONFIGURATION
//  Macro IBEX_IMEM_RAND_STALL_EN.
//  - Defined: an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset)
//    advances every cycle. stall = (lfsr[1:0]==2'b00). A pending request then
//    sees deterministic pseudo-random grant wait states. Latency after grant
//    is unchanged.
//  - Undefined: no LFSR, stall=0, and every request is granted in the cycle
//    it is raised.
// STRUCTURE
//  - ibex_pkg holds the response pipeline entry struct imem_rsp_t
//    {logic valid; logic err; logic [31:0] rdata;} and the constant
//    IMEM_LFSR_SEED = 8'hA5.
//  - Sub-module ibex_imem_stall_lfsr is instantiated only under
//    IBEX_IMEM_RAND_STALL_EN. Ports: clk_i, rst_ni, stall_o.
//  - RAM is an inferred single-write, async-read array. The pipeline is an
//    array of imem_rsp_t.
// TESTING
//  1. Preload RAM[0]=32'h0000_0013, RAM[1]=32'h0010_0093. Req addr 0 then 4
//     on consecutive cycles, RspLatency=2, macro off -> gnt both cycles;
//     rvalid at +2 and +3 with those words; err=0.
//  2. Req addr BaseAddr+MemWords*4 -> gnt; rvalid after RspLatency with
//     err=1, rdata=0. Same result for addr BaseAddr-4 when BaseAddr=32'h8000.
//  3. Continuous req for 8 cycles -> outstanding_o holds 2 in steady state;
//     8 rvalids in order; outstanding_o returns to 0.
//  4. Preload RAM[5]=A, then in one cycle write RAM[5]=B and grant addr 20
//     -> response A. Next read of addr 20 -> B.
//  5. Assert rst_ni low while 2 responses are in flight -> rvalid=0,
//     outstanding_o=0; no rvalid after release.
//  6. Macro on, constant req -> first gnt pattern matches the LFSR model
//     from seed 8'hA5; each gnt's rvalid is exactly RspLatency cycles later.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Response pipeline entry and stall-LFSR seed.
package ibex_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } imem_rsp_t;

    localparam logic [7:0] IMEM_LFSR_SEED = 8'hA5;

endpackage

// File: rtl/ibex_imem_stall_lfsr.sv
// Pseudo-random grant stall source (x^8+x^6+x^5+x^4+1), built only with IBEX_IMEM_RAND_STALL_EN.
// Latency: stall_o is combinational from the LFSR state, which advances every cycle.
// Backpressure: none; free-running.
`ifdef IBEX_IMEM_RAND_STALL_EN
module ibex_imem_stall_lfsr
    import ibex_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    output logic stall_o
);

    logic [7:0] lfsr_q;
    logic       feedback;

    assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= IMEM_LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], feedback};
        end
    end

    assign stall_o = (lfsr_q[1:0] == 2'b00);

endmodule
`endif

// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch responder: RAM-backed word reads; optional random grant stalls (IBEX_IMEM_RAND_STALL_EN).
// Latency: grant is combinational; rvalid exactly RspLatency cycles after grant, in order.
// Backpressure: only via withheld grant; rvalid cannot be stalled.
module ibex_instr_mem_responder
    import ibex_pkg::*;
#(
    parameter int unsigned MemWords   = 4096,
    parameter logic [31:0] BaseAddr   = 32'h0000_0000,
    parameter int unsigned RspLatency = 2,
    localparam int unsigned AW        = $clog2(MemWords)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_waddr_i,
    input  logic [31:0]   mem_wdata_i,
    output logic [3:0]    outstanding_o
);

    logic        stall;
    logic [29:0] word_off;
    logic        in_range;
    logic [AW-1:0] rd_idx;
    imem_rsp_t   rsp_new;
    imem_rsp_t   pipe_q [RspLatency];
    logic [31:0] mem [MemWords];
    logic [3:0]  outstanding_q;
    logic        unused_addr;

`ifdef IBEX_IMEM_RAND_STALL_EN
    ibex_imem_stall_lfsr u_stall_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .stall_o (stall)
    );
`else
    assign stall = 1'b0;
`endif

    // Gated by reset so the grant reads 0 while the block is held in reset.
    assign instr_gnt_o = instr_req_i & ~stall & rst_ni;

    // BaseAddr is word-aligned, so the decode can work on word addresses only.
    assign unused_addr = ^instr_addr_i[1:0];
    assign word_off    = instr_addr_i[31:2] - BaseAddr[31:2];
    assign in_range    = (instr_addr_i[31:2] >= BaseAddr[31:2]) &&
                         (word_off < 30'(MemWords));
    assign rd_idx      = word_off[AW-1:0];

    always_comb begin
        rsp_new = '0;
        if (instr_gnt_o) begin
            rsp_new.valid = 1'b1;
            if (in_range) begin
                rsp_new.rdata = mem[rd_idx];
            end else begin
                rsp_new.err = 1'b1;
            end
        end
    end

    // Read happens combinationally above, so a same-edge write is seen only by later grants.
    always_ff @(posedge clk_i) begin
        if (mem_we_i) begin
            mem[mem_waddr_i] <= mem_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(RspLatency); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= rsp_new;
            for (int i = 1; i < int'(RspLatency); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Empty slots are loaded as all-zero, so data and err read 0 whenever rvalid is low.
    assign instr_rvalid_o = pipe_q[RspLatency-1].valid;
    assign instr_err_o    = pipe_q[RspLatency-1].err;
    assign instr_rdata_o  = pipe_q[RspLatency-1].rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= 4'd0;
        end else begin
            case ({instr_gnt_o, instr_rvalid_o})
                2'b10:   outstanding_q <= outstanding_q + 4'd1;
                2'b01:   outstanding_q <= outstanding_q - 4'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign outstanding_o = outstanding_q;

`ifndef SYNTHESIS
    addr_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (instr_req_i && !instr_gnt_o) |=> $stable(instr_addr_i))
        else $warning("instr_addr_i changed while request pending");

    latency_range_a: assert property (@(posedge clk_i)
        (RspLatency >= 1) && (RspLatency <= 8))
        else $error("RspLatency outside 1..8");
`endif

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Scoreboard bench: driver issues directed fetches, monitor checks every cycle at the falling edge.
module tb_ibex_instr_mem_responder;

    localparam int unsigned MW   = 64;
    localparam int unsigned AWB  = 6;
    localparam int unsigned L    = 2;
    localparam logic [31:0] BASE = 32'h0000_8000;

    logic            clk;
    logic            rst_n;
    logic            req;
    logic [31:0]     addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;
    logic            err;
    logic            we;
    logic [AWB-1:0]  waddr;
    logic [31:0]     wdata;
    logic [3:0]      outstanding;

    logic            exp_err;
    logic [31:0]     exp_data;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_out = 0;
    logic exp_gnt;
    logic rv;
    logic m_stall;

    ibex_instr_mem_responder #(
        .MemWords   (MW),
        .BaseAddr   (BASE),
        .RspLatency (L)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_req_i    (req),
        .instr_addr_i   (addr),
        .instr_gnt_o    (gnt),
        .instr_rvalid_o (rvalid),
        .instr_rdata_o  (rdata),
        .instr_err_o    (err),
        .mem_we_i       (we),
        .mem_waddr_i    (waddr),
        .mem_wdata_i    (wdata),
        .outstanding_o  (outstanding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

`ifdef IBEX_IMEM_RAND_STALL_EN
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    assign m_stall = (m_lfsr[1:0] == 2'b00);
`else
    assign m_stall = 1'b0;
`endif

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Monitor: expected responses are queued on each expected grant and retired on their due cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_out = 0;
            check("rst_gnt", 32'(gnt), 0);
            check("rst_rvalid", 32'(rvalid), 0);
            check("rst_rdata", rdata, 0);
            check("rst_err", 32'(err), 0);
            check("rst_outstanding", 32'(outstanding), 0);
        end else begin
            exp_gnt = req & ~m_stall;
            check("gnt", 32'(gnt), 32'(exp_gnt));
            check("outstanding", 32'(outstanding), 32'(exp_out));
            rv = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                rv = 1'b1;
                check("rvalid", 32'(rvalid), 1);
                check("rdata", rdata, q[0].rdata);
                check("err", 32'(err), 32'(q[0].err));
                void'(q.pop_front());
            end else begin
                check("idle_rvalid", 32'(rvalid), 0);
                check("idle_rdata", rdata, 0);
                check("idle_err", 32'(err), 0);
            end
            exp_out = exp_out + int'(exp_gnt) - int'(rv);
            if (exp_gnt) q.push_back('{cyc + int'(L), exp_err, exp_data});
        end
    end

    task automatic preload(input int idx, input logic [31:0] d);
        @(posedge clk); #1;
        we = 1'b1; waddr = idx[AWB-1:0]; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic e, input logic [31:0] d);
        int w = 0;
        @(posedge clk); #1;
        req = 1'b1; addr = a; exp_err = e; exp_data = d;
        @(negedge clk);
        while (!gnt && w < 64) begin
            @(negedge clk);
            w++;
        end
        check("gnt_wait", 32'(gnt), 1);
    endtask

    // Fetch and preload write land on the same clock edge.
    task automatic issue_w(input logic [31:0] a, input logic [31:0] d, input int idx, input logic [31:0] wd);
        @(posedge clk); #1;
        while (m_stall) begin
            @(posedge clk); #1;
        end
        req = 1'b1; addr = a; exp_err = 1'b0; exp_data = d;
        we = 1'b1; waddr = idx[AWB-1:0]; wdata = wd;
        @(negedge clk);
        check("gnt_same_cycle_write", 32'(gnt), 1);
        @(posedge clk); #1;
        we = 1'b0; req = 1'b0;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; waddr = '0; wdata = '0;
        exp_err = 1'b0; exp_data = '0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back in-range fetches; low address bits ignored.
        preload(0, 32'h0000_0013);
        preload(1, 32'h0010_0093);
        issue(BASE, 1'b0, 32'h0000_0013);
        issue(BASE + 32'd4, 1'b0, 32'h0010_0093);
        issue(BASE + 32'd6, 1'b0, 32'h0010_0093);
        idle(4);

        // Range boundaries above and below the window.
        preload(63, 32'hCAFE_F00D);
        issue(BASE + 32'd252, 1'b0, 32'hCAFE_F00D);
        issue(BASE + 32'd256, 1'b1, 32'h0);
        issue(BASE - 32'd4, 1'b1, 32'h0);
        issue(32'h0000_0000, 1'b1, 32'h0);
        idle(4);

        // Continuous request stream.
        for (int i = 0; i < 8; i++) preload(8 + i, 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 8; i++) issue(BASE + 32'((8 + i) * 4), 1'b0, 32'hA000_0000 + 32'(i));
        idle(6);

        // Read-before-write on a same-cycle preload.
        preload(5, 32'hAAAA_5555);
        issue_w(BASE + 32'd20, 32'hAAAA_5555, 5, 32'hBBBB_6666);
        issue(BASE + 32'd20, 1'b0, 32'hBBBB_6666);
        idle(4);

        // Reset with responses in flight.
        issue(BASE, 1'b0, 32'h0000_0013);
        issue(BASE + 32'd4, 1'b0, 32'h0010_0093);
        @(posedge clk); #1;
        req = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Traffic still works after reset.
        issue(BASE + 32'd4, 1'b0, 32'h0010_0093);
        idle(5);
        check("queue_drained", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
